// File: rtl/mul_share_arb.sv
// Round-robin arbiter that shares one pipelined 32x32 multiplier between two requesters.
// A tag pipe matched to the multiplier depth routes each product back to its owning port.
module mul_share_arb #(
  parameter int LAT   = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [31:0]      p0_a,
  input  logic [31:0]      p0_b,
  input  logic [TAG_W-1:0] p0_tag,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [31:0]      p1_a,
  input  logic [31:0]      p1_b,
  input  logic [TAG_W-1:0] p1_tag,
  output logic             r0_valid,
  output logic [63:0]      r0_prod,
  output logic [TAG_W-1:0] r0_tag,
  output logic             r1_valid,
  output logic [63:0]      r1_prod,
  output logic [TAG_W-1:0] r1_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_r,
  output logic [CNT_W-1:0] inflight,
  output logic             busy
);

  logic             prio_q, prio_d;
  logic             gnt0, gnt1, hs, retire;
  logic [31:0]      mul_a_q, mul_b_q, mul_a_d, mul_b_d;
  logic [LAT:0]     vld_q, id_q;
  logic [TAG_W-1:0] tag_q [LAT+1];
  logic             r0_valid_q, r1_valid_q;
  logic [63:0]      r0_prod_q, r1_prod_q;
  logic [TAG_W-1:0] r0_tag_q, r1_tag_q;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  always_comb begin
    gnt0     = p0_valid & (~p1_valid | ~prio_q);
    gnt1     = p1_valid & (~p0_valid | prio_q);
    hs       = (gnt0 | gnt1) & ~rst;
    retire   = r0_valid_q | r1_valid_q;
    prio_d   = prio_q;
    mul_a_d  = '0;
    mul_b_d  = '0;
    inflight_d = inflight_q;
    // After a grant the pointer moves to the port that lost; granting port 0 means prio becomes 1.
    if (hs) begin
      prio_d  = gnt0;
      mul_a_d = gnt1 ? p1_a : p0_a;
      mul_b_d = gnt1 ? p1_b : p0_b;
    end
    if (hs && !retire) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!hs && retire) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      vld_q      <= '0;
      id_q       <= '0;
      for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
      r0_prod_q  <= '0;
      r1_prod_q  <= '0;
      r0_tag_q   <= '0;
      r1_tag_q   <= '0;
      inflight_q <= '0;
    end else begin
      prio_q   <= prio_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      vld_q    <= {vld_q[LAT-1:0], hs};
      id_q     <= {id_q[LAT-1:0], gnt1};
      tag_q[0] <= gnt1 ? p1_tag : p0_tag;
      for (int i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
      // The last tag stage lines up with the multiplier output for the same operation.
      r0_valid_q <= vld_q[LAT] & ~id_q[LAT];
      r1_valid_q <= vld_q[LAT] & id_q[LAT];
      if (vld_q[LAT] && !id_q[LAT]) begin
        r0_prod_q <= mul_r;
        r0_tag_q  <= tag_q[LAT];
      end
      if (vld_q[LAT] && id_q[LAT]) begin
        r1_prod_q <= mul_r;
        r1_tag_q  <= tag_q[LAT];
      end
      inflight_q <= inflight_d;
    end
  end

  assign p0_ready = gnt0 & ~rst;
  assign p1_ready = gnt1 & ~rst;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign r0_valid = r0_valid_q;
  assign r0_prod  = r0_prod_q;
  assign r0_tag   = r0_tag_q;
  assign r1_valid = r1_valid_q;
  assign r1_prod  = r1_prod_q;
  assign r1_tag   = r1_tag_q;
  assign inflight = inflight_q;
  assign busy     = |inflight_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed testbench for mul_share_arb with a behavioural pipelined multiplier.
// Results are checked against an expected-result queue with due cycles.
module tb_mul_share_arb;

  localparam int LAT   = 8;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             p0_valid, p1_valid;
  logic             p0_ready, p1_ready;
  logic [31:0]      p0_a, p0_b, p1_a, p1_b;
  logic [TAG_W-1:0] p0_tag, p1_tag;
  logic             r0_valid, r1_valid;
  logic [63:0]      r0_prod, r1_prod;
  logic [TAG_W-1:0] r0_tag, r1_tag;
  logic [31:0]      mul_a, mul_b;
  logic [63:0]      mul_r;
  logic [CNT_W-1:0] inflight;
  logic             busy;

  typedef struct {
    logic             port;
    logic [63:0]      prod;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t        expQ[$];
  int          cyc = 0;
  int          checkCount = 0;
  int          passCount = 0;
  bit          monEn = 1'b0;
  logic [63:0] mp [LAT];

  mul_share_arb #(.LAT(LAT), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_a(p0_a), .p0_b(p0_b), .p0_tag(p0_tag),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_a(p1_a), .p1_b(p1_b), .p1_tag(p1_tag),
    .r0_valid(r0_valid), .r0_prod(r0_prod), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_prod(r1_prod), .r1_tag(r1_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared multiplier model: LAT register stages, no reset.
  always @(posedge clk) begin
    mp[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_r = mp[LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checkCount++;
    if (obs !== expv) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, obs, expv, cyc);
    else passCount++;
  endtask

  // Every returned result must match the oldest outstanding operation at its due cycle.
  always @(negedge clk) begin
    if (monEn) begin
      if (expQ.size() != 0 && expQ[0].due == cyc) begin
        checkOutput("resultValid", 64'({r1_valid, r0_valid}), expQ[0].port ? 64'd2 : 64'd1);
        checkOutput("resultProd", r1_valid ? r1_prod : r0_prod, expQ[0].prod);
        checkOutput("resultTag", 64'(r1_valid ? r1_tag : r0_tag), 64'(expQ[0].tag));
        void'(expQ.pop_front());
      end else if (r0_valid || r1_valid) begin
        checkOutput("unexpectedResult", 64'({r1_valid, r0_valid}), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [TAG_W-1:0] t0, input logic v1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic [TAG_W-1:0] t1,
                               input logic [1:0] expRdy);
    exp_t e;
    @(posedge clk);
    #1;
    p0_valid = v0; p0_a = a0; p0_b = b0; p0_tag = t0;
    p1_valid = v1; p1_a = a1; p1_b = b1; p1_tag = t1;
    @(negedge clk);
    checkOutput("ready", 64'({p1_ready, p0_ready}), 64'(expRdy));
    if (expRdy[0]) begin
      e.port = 1'b0; e.prod = {32'b0, a0} * {32'b0, b0}; e.tag = t0; e.due = cyc + LAT + 2;
      expQ.push_back(e);
    end
    if (expRdy[1]) begin
      e.port = 1'b1; e.prod = {32'b0, a1} * {32'b0, b1}; e.tag = t1; e.due = cyc + LAT + 2;
      expQ.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int i0, i1;
    rst = 1'b1;
    p0_valid = 1'b1; p1_valid = 1'b1;
    p0_a = '0; p0_b = '0; p0_tag = '0;
    p1_a = '0; p1_b = '0; p1_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetReady", 64'({p1_ready, p0_ready}), 64'd0);
    checkOutput("resetInflight", 64'(inflight), 64'd0);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetResultValid", 64'({r1_valid, r0_valid}), 64'd0);
    checkOutput("resetMulA", 64'(mul_a), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
    monEn = 1'b1;

    // Single op on port 0: 3*5, tag 2.
    applyStimulus(1'b1, 32'd3, 32'd5, 4'h2, 1'b0, 32'd0, 32'd0, 4'h0, 2'b01);
    for (int k = 1; k <= 10; k++) begin
      idleCycles(1);
      checkOutput("singleInflight", 64'(inflight), 64'd1);
    end
    idleCycles(1);
    checkOutput("singleInflightDone", 64'(inflight), 64'd0);
    checkOutput("singleBusyDone", 64'(busy), 64'd0);
    checkOutput("singleProdHeld", r0_prod, 64'd15);
    checkOutput("singleTagHeld", 64'(r0_tag), 64'h2);

    // Max operands on port 1.
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h7, 2'b10);
    idleCycles(11);
    checkOutput("maxProd", r1_prod, 64'hFFFF_FFFE_0000_0001);
    checkOutput("maxTag", 64'(r1_tag), 64'h7);
    checkOutput("otherPortHeld", r0_prod, 64'd15);

    // Contention: each port holds its request until accepted; grants alternate from port 0.
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 32'(100 + i0), 32'd7, 4'(i0 + 1), 1'b1, 32'(200 + i1), 32'd9, 4'(i1 + 8),
                    (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k % 2 == 0) i0++;
      else i1++;
    end
    idleCycles(12);

    // Full-throughput stream of 20 ops on port 0.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 32'(k), 32'(k + 1), 4'(k), 1'b0, 32'd0, 32'd0, 4'h0, 2'b01);
      checkOutput("streamInflight", 64'(inflight), 64'((k < 10) ? k : 10));
      checkOutput("streamBusy", 64'(busy), 64'(k != 0));
    end
    for (int j = 1; j <= 11; j++) begin
      idleCycles(1);
      checkOutput("drainInflight", 64'(inflight), 64'(11 - j));
    end
    idleCycles(1);

    // Reset mid-flight with prio left pointing at port 1.
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 32'd11, 32'd13, 4'h1, 2'b10);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 32'd12, 32'd13, 4'h2, 2'b10);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 32'd14, 32'd13, 4'h3, 2'b10);
    applyStimulus(1'b1, 32'd21, 32'd3, 4'h4, 1'b0, 32'd0, 32'd0, 4'h0, 2'b01);
    @(posedge clk);
    #1;
    rst = 1'b1; p0_valid = 1'b1; p1_valid = 1'b1;
    @(negedge clk);
    checkOutput("midResetReady", 64'({p1_ready, p0_ready}), 64'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
    @(negedge clk);
    checkOutput("postResetInflight", 64'(inflight), 64'd0);
    checkOutput("postResetBusy", 64'(busy), 64'd0);
    checkOutput("postResetMulA", 64'(mul_a), 64'd0);
    checkOutput("postResetMulB", 64'(mul_b), 64'd0);
    checkOutput("postResetR0Prod", r0_prod, 64'd0);
    checkOutput("postResetR1Prod", r1_prod, 64'd0);
    checkOutput("postResetR1Tag", 64'(r1_tag), 64'd0);
    for (int k = 0; k < 14; k++) begin
      idleCycles(1);
      checkOutput("discardedResult", 64'({r1_valid, r0_valid}), 64'd0);
    end

    // prio was cleared by reset, so contention must grant port 0.
    applyStimulus(1'b1, 32'h1234, 32'h10, 4'hA, 1'b1, 32'd5, 32'd5, 4'hB, 2'b01);
    idleCycles(12);
    checkOutput("finalProd", r0_prod, 64'h12340);
    checkOutput("finalInflight", 64'(inflight), 64'd0);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
